// File: rtl/ureg_defs.sv
// Mode encodings shared by univ_reg and anything that drives its mode input.
package ureg_defs;

    localparam int         UREG_MODE_W = 3;

    localparam logic [2:0] UREG_HOLD = 3'd0;
    localparam logic [2:0] UREG_LOAD = 3'd1;
    localparam logic [2:0] UREG_SHL  = 3'd2;
    localparam logic [2:0] UREG_SHR  = 3'd3;
    localparam logic [2:0] UREG_ROTL = 3'd4;
    localparam logic [2:0] UREG_ROTR = 3'd5;
    localparam logic [2:0] UREG_CNTU = 3'd6;
    localparam logic [2:0] UREG_CNTD = 3'd7;

endpackage

// File: rtl/dff_cell.sv
// Single-bit rising-edge D flip-flop with async active-low reset to a per-bit value.
module dff_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic D,
    input  logic CP,
    input  logic n_rst,
    output logic Q,
    output logic Qbar
);

    logic r_q;

    always_ff @(posedge CP or negedge n_rst) begin
        if (!n_rst) begin
            r_q <= RST_BIT;
        end else begin
            r_q <= D;
        end
    end

    assign Q    = r_q;
    assign Qbar = ~r_q;

endmodule

// File: rtl/univ_reg.sv
// WIDTH-bit multi-mode register: hold, load, shift, rotate, count up/down.
// Optional synchronous clear port is compiled in with UREG_SYNC_CLR_EN.
module univ_reg
    import ureg_defs::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                   CP,
    input  logic                   n_rst,
    input  logic [UREG_MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]       D,
    input  logic                   SI_L,
    input  logic                   SI_R,
    output logic [WIDTH-1:0]       Q,
    output logic [WIDTH-1:0]       Qbar,
    output logic                   SO_L,
    output logic                   SO_R,
    output logic                   TC
`ifdef UREG_SYNC_CLR_EN
    ,
    input  logic                   clr
`endif
);

    logic             w_clr;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qbar;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_rotl;
    logic [WIDTH-1:0] w_rotr;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_next;
    logic             r_tc;

`ifdef UREG_SYNC_CLR_EN
    assign w_clr = clr;
`else
    assign w_clr = 1'b0;
`endif

    // A 1-bit register has no neighbours: shifts take the serial input, rotates hold.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_shl  = SI_L;
            assign w_shr  = SI_R;
            assign w_rotl = w_q;
            assign w_rotr = w_q;
        end else begin : g_wn
            assign w_shl  = {w_q[WIDTH-2:0], SI_L};
            assign w_shr  = {SI_R, w_q[WIDTH-1:1]};
            assign w_rotl = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
            assign w_rotr = {w_q[0], w_q[WIDTH-1:1]};
        end
    endgenerate

    assign w_inc = w_q + WIDTH'(1);
    assign w_dec = w_q - WIDTH'(1);

    always_comb begin
        w_next = w_q;
        if (w_clr) begin
            w_next = '0;
        end else begin
            case (mode)
                UREG_HOLD: w_next = w_q;
                UREG_LOAD: w_next = D;
                UREG_SHL:  w_next = w_shl;
                UREG_SHR:  w_next = w_shr;
                UREG_ROTL: w_next = w_rotl;
                UREG_ROTR: w_next = w_rotr;
                UREG_CNTU: w_next = w_inc;
                UREG_CNTD: w_next = w_dec;
                default:   w_next = w_q;
            endcase
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            dff_cell #(
                .RST_BIT (RST_VAL[i])
            ) u_cell (
                .D     (w_next[i]),
                .CP    (CP),
                .n_rst (n_rst),
                .Q     (w_q[i]),
                .Qbar  (w_qbar[i])
            );
        end
    endgenerate

    // TC flags the value just reached, so it is judged on w_next, not the old Q.
    always_ff @(posedge CP or negedge n_rst) begin
        if (!n_rst) begin
            r_tc <= 1'b0;
        end else if (w_clr) begin
            r_tc <= 1'b0;
        end else begin
            case (mode)
                UREG_CNTU: r_tc <= (w_next == {WIDTH{1'b1}});
                UREG_CNTD: r_tc <= (w_next == {WIDTH{1'b0}});
                default:   r_tc <= 1'b0;
            endcase
        end
    end

    assign Q    = w_q;
    assign Qbar = w_qbar;
    assign SO_L = w_q[WIDTH-1];
    assign SO_R = w_q[0];
    assign TC   = r_tc;

endmodule

// File: tb/tb_univ_reg.sv
// Bench for univ_reg at WIDTH=4, RST_VAL=1010; exercises clr when UREG_SYNC_CLR_EN is defined.
module tb_univ_reg;
    import ureg_defs::*;

    localparam int         W  = 4;
    localparam logic [3:0] RV = 4'b1010;

    logic       CP;
    logic       n_rst;
    logic [2:0] mode;
    logic [3:0] D;
    logic       SI_L;
    logic       SI_R;
    logic [3:0] Q;
    logic [3:0] Qbar;
    logic       SO_L;
    logic       SO_R;
    logic       TC;
`ifdef UREG_SYNC_CLR_EN
    logic       clr;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [3:0] mq;
    logic       mtc;

    univ_reg #(
        .WIDTH   (W),
        .RST_VAL (RV)
    ) dut (
        .CP    (CP),
        .n_rst (n_rst),
        .mode  (mode),
        .D     (D),
        .SI_L  (SI_L),
        .SI_R  (SI_R),
        .Q     (Q),
        .Qbar  (Qbar),
        .SO_L  (SO_L),
        .SO_R  (SO_R),
        .TC    (TC)
`ifdef UREG_SYNC_CLR_EN
        ,
        .clr   (clr)
`endif
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // Reference behaviour computed from the mode rules with plain integer arithmetic.
    task automatic modelEdge(input logic [2:0] m, input logic [3:0] d,
                             input logic sl, input logic sr, input logic c);
        int v;
        v = int'(mq);
        if (c) begin
            mq  = 4'd0;
            mtc = 1'b0;
        end else begin
            case (m)
                3'd1:    v = int'(d);
                3'd2:    v = (v * 2 + int'(sl)) % 16;
                3'd3:    v = int'(sr) * 8 + v / 2;
                3'd4:    v = (v * 2) % 16 + v / 8;
                3'd5:    v = (v % 2) * 8 + v / 2;
                3'd6:    v = (v + 1) % 16;
                3'd7:    v = (v + 15) % 16;
                default: v = v;
            endcase
            mq  = v[3:0];
            mtc = (m == 3'd6 && v == 15) || (m == 3'd7 && v == 0);
        end
    endtask

    task automatic doEdge(input logic [2:0] m, input logic [3:0] d,
                          input logic sl, input logic sr, input logic c);
        @(negedge CP);
        mode = m;
        D    = d;
        SI_L = sl;
        SI_R = sr;
`ifdef UREG_SYNC_CLR_EN
        clr  = c;
`endif
        @(posedge CP);
        #1;
        if (n_rst) modelEdge(m, d, sl, sr, c);
    endtask

    task automatic test_reset();
        logic [3:0] e;
        mode = UREG_LOAD;
        D    = 4'b1111;
        SI_L = 1'b1;
        SI_R = 1'b1;
`ifdef UREG_SYNC_CLR_EN
        clr  = 1'b0;
`endif
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        e = RV;
        for (int i = 0; i < 4; i++) begin
            @(posedge CP);
            #1;
            checks++;
            if ({Q, Qbar, SO_L, SO_R, TC} !== {e, ~e, e[3], e[0], 1'b0}) begin
                errors++;
                $display("[TB] FAIL reset_hold cyc %0d: got Q=%b Qbar=%b SOL=%b SOR=%b TC=%b, want Q=%b TC=0",
                         i, Q, Qbar, SO_L, SO_R, TC, e);
            end
        end
        mq  = RV;
        mtc = 1'b0;
        @(negedge CP);
        mode  = UREG_HOLD;
        n_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            doEdge(UREG_HOLD, 4'b0101, 1'b1, 1'b1, 1'b0);
            checks++;
            if ({Q, Qbar, TC} !== {e, ~e, 1'b0}) begin
                errors++;
                $display("[TB] FAIL reset_release_hold %0d: got Q=%b TC=%b, want Q=%b TC=0", i, Q, TC, e);
            end
        end
    endtask

    task automatic test_load_shift();
        logic [2:0] ms [3] = '{UREG_LOAD, UREG_SHL, UREG_SHR};
        logic [3:0] es [3] = '{4'b0011, 4'b0111, 4'b0011};
        logic [3:0] e;
        for (int i = 0; i < 3; i++) begin
            doEdge(ms[i], 4'b0011, 1'b1, 1'b0, 1'b0);
            e = es[i];
            checks++;
            if ({Q, Qbar, SO_L, SO_R, TC} !== {e, ~e, e[3], e[0], 1'b0}) begin
                errors++;
                $display("[TB] FAIL load_shift step %0d: got Q=%b Qbar=%b SOL=%b SOR=%b TC=%b, want Q=%b",
                         i, Q, Qbar, SO_L, SO_R, TC, e);
            end
        end
    endtask

    task automatic test_rotate();
        logic [2:0] ms [4] = '{UREG_LOAD, UREG_ROTL, UREG_ROTR, UREG_ROTR};
        logic [3:0] es [4] = '{4'b1001, 4'b0011, 4'b1001, 4'b1100};
        logic [3:0] e;
        for (int i = 0; i < 4; i++) begin
            doEdge(ms[i], 4'b1001, 1'b0, 1'b0, 1'b0);
            e = es[i];
            checks++;
            if ({Q, Qbar, SO_L, SO_R, TC} !== {e, ~e, e[3], e[0], 1'b0}) begin
                errors++;
                $display("[TB] FAIL rotate step %0d: got Q=%b SOL=%b SOR=%b TC=%b, want Q=%b",
                         i, Q, SO_L, SO_R, TC, e);
            end
        end
    endtask

    task automatic test_count_wrap();
        logic [2:0] ms [7] = '{UREG_LOAD, UREG_CNTU, UREG_CNTU, UREG_CNTU, UREG_LOAD, UREG_CNTD, UREG_CNTD};
        logic [3:0] ds [7] = '{4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        logic [3:0] es [7] = '{4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b1111};
        logic       ts [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] e;
        for (int i = 0; i < 7; i++) begin
            doEdge(ms[i], ds[i], 1'b0, 1'b0, 1'b0);
            e = es[i];
            checks++;
            if ({Q, Qbar, TC} !== {e, ~e, ts[i]}) begin
                errors++;
                $display("[TB] FAIL count_wrap step %0d: got Q=%b TC=%b, want Q=%b TC=%b", i, Q, TC, e, ts[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        doEdge(UREG_LOAD, 4'b0100, 1'b0, 1'b0, 1'b0);
        doEdge(UREG_CNTU, 4'b0000, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({Q, TC} !== {4'b0101, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_pre: got Q=%b TC=%b, want Q=0101 TC=0", Q, TC);
        end
        #2 n_rst = 1'b0;
        #1;
        mq  = RV;
        mtc = 1'b0;
        checks++;
        if ({Q, Qbar, TC} !== {RV, ~RV, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_mid: got Q=%b TC=%b before next edge, want Q=%b TC=0", Q, TC, RV);
        end
        @(posedge CP);
        #1;
        checks++;
        if (Q !== RV) begin
            errors++;
            $display("[TB] FAIL async_edge_ignored: got Q=%b, want Q=%b", Q, RV);
        end
        n_rst = 1'b1;
        doEdge(UREG_CNTU, 4'b0000, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({Q, TC} !== {4'b1011, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_release_count: got Q=%b TC=%b, want Q=1011 TC=0", Q, TC);
        end
    endtask

`ifdef UREG_SYNC_CLR_EN
    task automatic test_clr();
        doEdge(UREG_LOAD, 4'b1110, 1'b0, 1'b0, 1'b0);
        doEdge(UREG_CNTU, 4'b0000, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({Q, TC} !== {4'b1111, 1'b1}) begin
            errors++;
            $display("[TB] FAIL clr_setup: got Q=%b TC=%b, want Q=1111 TC=1", Q, TC);
        end
        doEdge(UREG_LOAD, 4'b1111, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({Q, Qbar, TC} !== {4'b0000, 4'b1111, 1'b0}) begin
            errors++;
            $display("[TB] FAIL clr_over_load: got Q=%b TC=%b, want Q=0000 TC=0", Q, TC);
        end
        clr = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [2:0] m;
        logic [3:0] d;
        logic       sl;
        logic       sr;
        logic       c;
        for (int i = 0; i < 150; i++) begin
            m  = 3'($urandom_range(0, 7));
            d  = 4'($urandom);
            sl = 1'($urandom);
            sr = 1'($urandom);
`ifdef UREG_SYNC_CLR_EN
            c  = ($urandom_range(0, 7) == 0);
`else
            c  = 1'b0;
`endif
            doEdge(m, d, sl, sr, c);
            checks++;
            if ({Q, Qbar, SO_L, SO_R, TC} !== {mq, ~mq, mq[3], mq[0], mtc}) begin
                errors++;
                $display("[TB] FAIL random %0d mode=%0d D=%b SIL=%b SIR=%b clr=%b: got Q=%b SOL=%b SOR=%b TC=%b, want Q=%b TC=%b",
                         i, m, d, sl, sr, c, Q, SO_L, SO_R, TC, mq, mtc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_shift();
        test_rotate();
        test_count_wrap();
        test_async_reset();
`ifdef UREG_SYNC_CLR_EN
        test_clr();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/univ_reg.md
# univ_reg

Parametrised multi-mode register: the successor to the single-bit edge-triggered D flip-flop. It provides a WIDTH-bit register with complementary outputs and eight operating modes: hold, parallel load, shift left/right, rotate left/right, count up and count down. It is the common storage/shift/count primitive for the bootcamp datapath labs, and sits directly behind combinational logic wherever a plain D flip-flop bank, shift register or counter was previously hand-built.

## Interface
Parameters:
- WIDTH, default 4: register width in bits; legal range ≥ 1.
- RST_VAL, default 0: value loaded into Q on reset, WIDTH bits.

Ports:
- CP  in  1  clock; all state updates on the rising edge.
- n_rst  in  1  reset. One clock; reset is asynchronous and active-low.
- mode  in  3  operation select; encoding under Operation.
- D  in  WIDTH  parallel load data.
- SI_L  in  1  serial input entering at bit 0 on shift left.
- SI_R  in  1  serial input entering at bit WIDTH-1 on shift right.
- Q  out  WIDTH  register state.
- Qbar  out  WIDTH  bitwise complement of Q, always.
- SO_L  out  1  equals Q[WIDTH-1]; the bit lost on the next shift left.
- SO_R  out  1  equals Q[0]; the bit lost on the next shift right.
- TC  out  1  terminal count; registered.
- clr  in  1  synchronous clear. Present only with UREG_SYNC_CLR_EN.

## Operation
Mode encoding, as 3-bit values:
- 0 HOLD: Q unchanged.
- 1 LOAD: Q <= D.
- 2 SHL: Q <= {Q[WIDTH-2:0], SI_L}.
- 3 SHR: Q <= {SI_R, Q[WIDTH-1:1]}.
- 4 ROTL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
- 5 ROTR: Q <= {Q[0], Q[WIDTH-1:1]}.
- 6 CNTU: Q <= Q + 1, modulo 2^WIDTH.
- 7 CNTD: Q <= Q - 1, modulo 2^WIDTH.

Rules:
- WIDTH = 1: SHL gives Q <= SI_L and SHR gives Q <= SI_R. ROTL and ROTR behave as HOLD.
- Counting wraps silently: all-ones + 1 = 0, and 0 - 1 = all-ones. There is no saturation.
- TC is registered. After an edge in CNTU, TC = 1 iff the new Q is all-ones. After an edge in CNTD, TC = 1 iff the new Q is 0. After an edge in any other mode, TC = 0.
- Qbar, SO_L and SO_R are combinational functions of Q only. They are never separately stored.

## Timing
- Latency: one CP rising edge from mode/D/SI sampling to the Q update. Inputs must be stable around the edge.
- Reset values: Q = RST_VAL, Qbar = ~RST_VAL, SO_L = RST_VAL[WIDTH-1], SO_R = RST_VAL[0], TC = 0.
- Reset assertion takes effect immediately, without waiting for CP. This includes reset mid-count or mid-shift, where the in-flight operation is discarded.
- During reset, CP edges are ignored.
- On deassertion, the first rising edge of CP with n_rst = 1 performs the selected mode.
- clr (when compiled in) has priority over mode and wins on simultaneous assertion. On the edge: Q <= 0 and TC <= 0. n_rst has priority over clr.

## Configuration
- Macro UREG_SYNC_CLR_EN.
- Defined: the clr port exists and acts as described under Timing.
- Undefined: there is no clr port, and the block behaves as if clr = 0.
- Every other behaviour is identical in both builds.

## Structure
- Shared package/include ureg_defs holds the localparams for the eight mode encodings: UREG_HOLD … UREG_CNTD. Testbenches reuse it.
- One sub-module, dff_cell: a single-bit D flip-flop with ports D, CP, n_rst, per-bit reset value, Q, Qbar. univ_reg instantiates WIDTH of them.
- univ_reg itself contains the next-state mux, the adder/subtractor and the TC register.

## Test plan
All scenarios use WIDTH = 4 and RST_VAL = 4'b1010.
- Reset: hold n_rst = 0 with CP toggling -> Q = 1010, Qbar = 0101, TC = 0 throughout. Release, mode HOLD for 2 edges -> Q stays 1010.
- Load and shift: LOAD with D = 0011; then SHL with SI_L = 1; then SHR with SI_R = 0 -> Q = 0011, then 0111, then 0011. SO_L/SO_R track Q[3]/Q[0] at each step.
- Rotate: LOAD 1001; then ROTL ×1 -> 0011; then ROTR ×2 -> 1100.
- Count wrap: LOAD 1110, then CNTU ×3 -> Q = 1111 with TC = 1, then 0000 with TC = 0, then 0001. Next, LOAD 0001 and CNTD ×2 -> 0000 with TC = 1, then 1111 with TC = 0.
- Async reset mid-count: in CNTU from 0100, drop n_rst between edges -> Q = 1010 before the next edge. Re-release and CNTU once -> 1011.
- clr (UREG_SYNC_CLR_EN build): assert clr with mode = LOAD and D = 1111 -> Q = 0000 and TC = 0 after the edge. In the build without the macro, the port is absent and the model compiles.
